// File: rtl/qspi_ddr_pkg.sv
// Shared types and constants for the QSPI DDR transfer engine.
// State encoding, byte/length widths and length decode.
package qspi_ddr_pkg;

  localparam int QSPI_BYTE_W = 8;
  localparam int LEN_W       = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_XFER  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DESEL = 2'd3;

  // A length field of zero encodes a full four-byte transfer.
  function automatic logic [2:0] len_to_n(
    input logic [LEN_W-1:0] len
  );
    return (len == '0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/qspi_ddr_capture.sv
// Read-side capture: slot marker delay line, byte shift-in and count.
// Raises last when the final expected byte is being captured.
module qspi_ddr_capture
  import qspi_ddr_pkg::*;
#(
  parameter int BW         = QSPI_BYTE_W,
  parameter int RD_LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          slot,
  input  logic [2:0]    n_bytes,
  input  logic [BW-1:0] din,
  output logic [4*BW-1:0] data,
  output logic          last
);

  logic [RD_LATENCY-1:0] dl_q;
  logic [2:0]            cnt_q;
  logic                  cap;

  assign cap  = dl_q[RD_LATENCY-1];
  assign last = cap && (cnt_q == n_bytes - 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q  <= '0;
      cnt_q <= '0;
      data  <= '0;
    end else begin
      dl_q <= {dl_q[RD_LATENCY-2:0], slot};
      if (clr) begin
        cnt_q <= '0;
        data  <= '0;
      end else if (cap) begin
        cnt_q <= cnt_q + 3'd1;
        data  <= {data[3*BW-1:0], din};
      end
    end
  end

endmodule

// File: rtl/qspi_ddr_xfer.sv
// Byte-per-clock QSPI transfer engine driving an iCE40 DDR pad wrapper.
// Owns chip select, SCK gating, output enable and read capture.
module qspi_ddr_xfer
  import qspi_ddr_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int RD_LATENCY = 3,
  parameter int MIN_DESEL  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_stb,
  input  logic                 i_wr,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_hold,
  input  logic [8*WIDTH-1:0]   i_data,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [8*WIDTH-1:0]   o_data,
  output logic                 o_cs_n,
  output logic                 o_sck_en,
  output logic                 o_ddr_oe,
  output logic [2*WIDTH-1:0]   o_ddr_data,
  input  logic [2*WIDTH-1:0]   i_ddr_data
);

  localparam int BW = 2 * WIDTH;
  localparam int DW = 4 * BW;

  state_t          state, state_nx;
  logic            accept;
  logic            wr_q;
  logic            hold_q;
  logic [2:0]      n_q;
  logic [DW-1:0]   sr_q;
  logic [2:0]      xcnt_q;
  logic [3:0]      dcnt_q;
  logic            xfer_last;
  logic            desel_done;
  logic            cap_last;
  logic            slot;

  assign accept     = i_stb && (state == ST_IDLE);
  assign xfer_last  = (xcnt_q == n_q - 3'd1);
  assign desel_done = (dcnt_q == 4'(MIN_DESEL - 1));
  assign o_busy     = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (accept) state_nx = ST_XFER;
      ST_XFER:
        if (xfer_last) begin
          if (!wr_q)       state_nx = ST_DRAIN;
          else if (hold_q) state_nx = ST_IDLE;
          else             state_nx = ST_DESEL;
        end
      ST_DRAIN:
        if (cap_last)
          state_nx = hold_q ? ST_IDLE : ST_DESEL;
      ST_DESEL:
        if (desel_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    o_sck_en   = 1'b0;
    o_ddr_oe   = 1'b0;
    o_ddr_data = '0;
    slot       = 1'b0;
    unique case (1'b1)
      (state == ST_XFER) && wr_q: begin
        o_sck_en   = 1'b1;
        o_ddr_oe   = 1'b1;
        o_ddr_data = sr_q[DW-1 -: BW];
      end
      (state == ST_XFER) && !wr_q: begin
        o_sck_en = 1'b1;
        slot     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q    <= 1'b0;
      hold_q  <= 1'b0;
      n_q     <= 3'd4;
      sr_q    <= '0;
      xcnt_q  <= '0;
      dcnt_q  <= '0;
      o_cs_n  <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      o_valid <= (state == ST_DRAIN) && cap_last;
      dcnt_q  <= (state == ST_DESEL) ? dcnt_q + 4'd1 : 4'd0;
      if (accept) begin
        wr_q   <= i_wr;
        hold_q <= i_hold;
        n_q    <= len_to_n(i_len);
        sr_q   <= i_data;
        xcnt_q <= '0;
        o_cs_n <= 1'b0;
      end else if (state == ST_XFER) begin
        xcnt_q <= xcnt_q + 3'd1;
        sr_q   <= sr_q << BW;
      end
      if (state_nx == ST_DESEL) o_cs_n <= 1'b1;
    end
  end

  qspi_ddr_capture #(
    .BW         (BW),
    .RD_LATENCY (RD_LATENCY)
  ) u_capture (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .clr     (accept && !i_wr),
    .slot    (slot),
    .n_bytes (n_q),
    .din     (i_ddr_data),
    .data    (o_data),
    .last    (cap_last)
  );

endmodule

// File: tb/tb_qspi_ddr_xfer.sv
// Directed bench for qspi_ddr_xfer with a latency-accurate flash model.
// Cycle 0 is the first cycle after the accepting clock edge.
module tb_qspi_ddr_xfer;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stb;
  logic        i_wr;
  logic [1:0]  i_len;
  logic        i_hold;
  logic [31:0] i_data;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_cs_n;
  logic        o_sck_en;
  logic        o_ddr_oe;
  logic [7:0]  o_ddr_data;
  logic [7:0]  i_ddr_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] flash_q[$];
  logic [8:0] hist[0:L];

  qspi_ddr_xfer #(
    .WIDTH(4), .RD_LATENCY(L), .MIN_DESEL(2)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_stb      (i_stb),
    .i_wr       (i_wr),
    .i_len      (i_len),
    .i_hold     (i_hold),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_cs_n     (o_cs_n),
    .o_sck_en   (o_sck_en),
    .o_ddr_oe   (o_ddr_oe),
    .o_ddr_data (o_ddr_data),
    .i_ddr_data (i_ddr_data)
  );

  initial forever #5 clk = ~clk;

  // Flash: a byte answers each read slot L cycles later.
  initial begin
    for (int i = 0; i <= L; i++) hist[i] = '0;
    i_ddr_data = '0;
    forever begin
      @(negedge clk);
      for (int i = L; i > 0; i--) hist[i] = hist[i-1];
      if (!o_cs_n && o_sck_en && !o_ddr_oe)
        hist[0] = {1'b1, (flash_q.size() > 0) ? flash_q.pop_front() : 8'hEE};
      else
        hist[0] = '0;
      i_ddr_data = hist[L][8] ? hist[L][7:0] : 8'h00;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [1:0] len,
                       input bit hold, input logic [31:0] data);
    @(negedge clk);
    i_stb = 1'b1; i_wr = wr; i_len = len;
    i_hold = hold; i_data = data;
    for (int k = 0; k < 40; k++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    if (o_busy) chk("accept_timeout", 32'(o_busy), 32'd0);
    step();
    i_stb = 1'b0;
  endtask

  task automatic run_read(input string tag, input logic [1:0] len,
                          input int exp_cyc, input logic [31:0] exp_data);
    int nv = 0;
    int vcyc = -1;
    logic [31:0] vdat = '0;
    bit oe_seen = 0;
    bit cs_hi = 0;
    issue(1'b0, len, 1'b0, 32'h0);
    for (int c = 0; c < 14; c++) begin
      if (o_valid) begin nv++; vcyc = c; vdat = o_data; end
      if (o_ddr_oe) oe_seen = 1;
      if (o_cs_n && nv == 0) cs_hi = 1;
      step();
    end
    chk({tag, "_nvalid"}, nv, 1);
    chk({tag, "_vcycle"}, vcyc, exp_cyc);
    chk({tag, "_data"}, vdat, exp_data);
    chk({tag, "_no_oe"}, 32'(oe_seen), 0);
    chk({tag, "_cs_low"}, 32'(cs_hi), 0);
    chk({tag, "_idle"}, 32'(o_busy), 0);
  endtask

  initial begin
    logic [7:0] wexp[0:4];
    logic [4:0] oe_e, cs_e, bz_e;
    int first_idle, noe, nv;
    logic [7:0] d0, d4;

    rst_n = 1'b0; i_stb = 0; i_wr = 0; i_len = 0;
    i_hold = 0; i_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_cs_n", 32'(o_cs_n), 1);
    chk("rst_sck", 32'(o_sck_en), 0);
    chk("rst_oe", 32'(o_ddr_oe), 0);
    chk("rst_ddr", 32'(o_ddr_data), 0);
    rst_n = 1'b1;

    // Write two bytes, no hold.
    wexp = '{8'hA5, 8'hC3, 8'h00, 8'h00, 8'h00};
    oe_e = 5'b00011; cs_e = 5'b11100; bz_e = 5'b01111;
    issue(1'b1, 2'd2, 1'b0, 32'hA5C3_1234);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("wr_oe_c%0d", c), 32'(o_ddr_oe), 32'(oe_e[c]));
      chk($sformatf("wr_sck_c%0d", c), 32'(o_sck_en), 32'(oe_e[c]));
      chk($sformatf("wr_ddr_c%0d", c), 32'(o_ddr_data), 32'(wexp[c]));
      chk($sformatf("wr_cs_c%0d", c), 32'(o_cs_n), 32'(cs_e[c]));
      chk($sformatf("wr_busy_c%0d", c), 32'(o_busy), 32'(bz_e[c]));
      step();
    end

    flash_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_read("rd4", 2'd0, 7, 32'h1122_3344);

    flash_q = '{8'h7E};
    run_read("rd1", 2'd1, 4, 32'h0000_007E);

    // Held write then read, CS low across both.
    issue(1'b1, 2'd1, 1'b1, 32'h0B00_0000);
    chk("wh_ddr", 32'(o_ddr_data), 32'h0B);
    chk("wh_oe", 32'(o_ddr_oe), 1);
    step();
    chk("wh_idle", 32'(o_busy), 0);
    chk("wh_cs_held", 32'(o_cs_n), 0);
    flash_q = '{8'hAA, 8'hBB, 8'hCC};
    run_read("rd3h", 2'd3, 6, 32'h00AA_BBCC);

    // Request held through busy: second command waits for IDLE.
    issue(1'b1, 2'd1, 1'b0, 32'h5A00_0000);
    i_stb = 1'b1;
    i_data = 32'h3C00_0000;
    first_idle = -1; noe = 0; d0 = 0; d4 = 0;
    for (int c = 0; c < 9; c++) begin
      if (i_stb && !o_busy && first_idle < 0) first_idle = c;
      if (o_ddr_oe) noe++;
      if (c == 0) d0 = o_ddr_data;
      if (c == 4) d4 = o_ddr_data;
      step();
      if (first_idle >= 0) i_stb = 1'b0;
    end
    chk("hs_first_idle", first_idle, 3);
    chk("hs_n_oe", noe, 2);
    chk("hs_byte0", 32'(d0), 32'h5A);
    chk("hs_byte1", 32'(d4), 32'h3C);

    // Reset in the middle of a read.
    flash_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    issue(1'b0, 2'd0, 1'b0, 32'h0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mr_cs_n", 32'(o_cs_n), 1);
    chk("mr_busy", 32'(o_busy), 0);
    chk("mr_sck", 32'(o_sck_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flash_q.delete();
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid) nv++;
      step();
    end
    chk("mr_no_valid", nv, 0);
    flash_q = '{8'h99};
    run_read("mr_next", 2'd1, 4, 32'h0000_0099);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
